// File: rtl/serial_byte_queue_if.sv
// rtl/serial_byte_queue_if.sv - serial write / byte read port bundle for serial_byte_queue
interface serial_byte_queue_if #(
   parameter int WIDTH = 8
);
   logic             data_in;
   logic             write_in;
   logic             dequeue_in;
   logic [WIDTH-1:0] data_out;
   logic             status_out;

   modport master (
      output data_in, write_in, dequeue_in,
      input  data_out, status_out
   );

   modport slave (
      input  data_in, write_in, dequeue_in,
      output data_out, status_out
   );
endinterface

// File: rtl/serial_byte_queue.sv
// rtl/serial_byte_queue.sv - serial-to-byte deserializer feeding a DEPTH-entry FIFO (LSB_FIRST_EN: LSB-first assembly)
module serial_byte_queue #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                clock1M,
   input  logic                reset,
   serial_byte_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic             write_q, dequeue_q;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             status_q, status_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic wr_evt, deq_evt, take_bit, byte_done, push, pop;

   always_comb begin
      wr_evt    = bus.write_in & ~write_q;
      deq_evt   = bus.dequeue_in & ~dequeue_q;
      take_bit  = wr_evt & ~status_q;
      byte_done = take_bit && (bit_cnt_q == LAST_BIT);
      pop       = deq_evt && (count_q != '0);
      // a pop in the same cycle frees the slot the completing byte needs
      push      = byte_done && ((count_q != FULL_CNT) || pop);

      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (take_bit) begin
`ifdef LSB_FIRST_EN
         shreg_d = {bus.data_in, shreg_q[WIDTH-1:1]};
`else
         shreg_d = {shreg_q[WIDTH-2:0], bus.data_in};
`endif
         bit_cnt_d = byte_done ? '0 : bit_cnt_q + BW'(1);
      end

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      data_d   = pop  ? mem_q[rd_ptr_q] : data_q;

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      status_d = (count_d == FULL_CNT);
   end

   always_ff @(posedge clock1M) begin
      if (!reset) begin
         write_q   <= 1'b0;
         dequeue_q <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         data_q    <= '0;
         status_q  <= 1'b0;
      end else begin
         write_q   <= bus.write_in;
         dequeue_q <= bus.dequeue_in;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         data_q    <= data_d;
         status_q  <= status_d;
      end
   end

   always_ff @(posedge clock1M) begin
      if (reset && push)
         mem_q[wr_ptr_q] <= shreg_d;
   end

   assign bus.data_out   = data_q;
   assign bus.status_out = status_q;
endmodule

// File: tb/tb_serial_byte_queue.sv
// tb/tb_serial_byte_queue.sv - directed self-checking bench for serial_byte_queue
`timescale 1ns/1ps
module tb_serial_byte_queue;
   logic clock1M = 1'b0;
   logic reset   = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   serial_byte_queue_if #(.WIDTH(8)) bus ();

   serial_byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
      .clock1M (clock1M),
      .reset   (reset),
      .bus     (bus)
   );

   always #500 clock1M = ~clock1M;

   task automatic cycles(input int n);
      repeat (n) @(negedge clock1M);
   endtask

   task automatic write_bit(input logic b, input int hold);
      bus.data_in  = b;
      bus.write_in = 1'b1;
      cycles(hold);
      bus.write_in = 1'b0;
      cycles(10);
   endtask

   task automatic write_byte(input logic [7:0] v);
      logic [7:0] t;
      t = v;
      for (int i = 0; i < 8; i++) begin
`ifdef LSB_FIRST_EN
         write_bit(t[i], 10);
`else
         write_bit(t[7-i], 10);
`endif
      end
   endtask

   task automatic dequeue(input int hold);
      bus.dequeue_in = 1'b1;
      cycles(hold);
      bus.dequeue_in = 1'b0;
      cycles(3);
   endtask

   task automatic chk_data(input string name, input logic [7:0] exp);
      checks++;
      if (bus.data_out !== exp) begin
         errors++;
         $display("FAIL %s: data_out=%02h expected %02h", name, bus.data_out, exp);
      end
   endtask

   task automatic chk_status(input string name, input logic exp);
      checks++;
      if (bus.status_out !== exp) begin
         errors++;
         $display("FAIL %s: status_out=%0b expected %0b", name, bus.status_out, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cycles(10);
      chk_data("reset_data", 8'h00);
      chk_status("reset_status", 1'b0);
      reset = 1'b1;
      cycles(2);
      dequeue(1);
      chk_data("empty_pop_data", 8'h00);
      chk_status("empty_pop_status", 1'b0);
   endtask

   task automatic test_single_byte();
      write_bit(1'b1, 10); write_bit(1'b1, 10); write_bit(1'b1, 10); write_bit(1'b1, 10);
      write_bit(1'b0, 10); write_bit(1'b0, 10); write_bit(1'b0, 10); write_bit(1'b0, 10);
      chk_status("single_status_before_pop", 1'b0);
      dequeue(1);
      chk_data("single_data", 8'hF0);
      chk_status("single_status", 1'b0);
   endtask

   task automatic test_fill();
      logic [7:0] seq [8];
      seq = '{8'hAA, 8'hCC, 8'hF0, 8'h0F, 8'h33, 8'h55, 8'h99, 8'hFF};
      for (int i = 0; i < 7; i++) write_byte(seq[i]);
      chk_status("fill_7_status", 1'b0);
      write_byte(seq[7]);
      chk_status("fill_8_status", 1'b1);
      write_byte(8'h00);
      chk_status("fill_ignored_status", 1'b1);
      dequeue(1);
      chk_data("fill_pop0", seq[0]);
      chk_status("fill_status_after_pop", 1'b0);
      for (int i = 1; i < 8; i++) begin
         dequeue(1);
         chk_data($sformatf("fill_pop%0d", i), seq[i]);
      end
      chk_status("fill_drained_status", 1'b0);
      dequeue(1);
      chk_data("fill_empty_hold", 8'hFF);
   endtask

   task automatic test_strobe_width();
      write_byte(8'h12);
      write_byte(8'h34);
      dequeue(20);
      chk_data("long_pop_first", 8'h12);
      dequeue(20);
      chk_data("long_pop_second", 8'h34);
      dequeue(20);
      chk_data("long_pop_empty_hold", 8'h34);
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq [3];
      seq = '{8'h0F, 8'hAA, 8'h55};
      for (int i = 0; i < 3; i++) begin
         write_byte(seq[i]);
         chk_status($sformatf("interleave_status_w%0d", i), 1'b0);
         dequeue(1);
         chk_data($sformatf("interleave_data%0d", i), seq[i]);
      end
   endtask

   task automatic test_reset_mid_byte();
      write_bit(1'b1, 10); write_bit(1'b1, 10); write_bit(1'b1, 10);
      reset = 1'b0;
      cycles(2);
      chk_data("midreset_data", 8'h00);
      reset = 1'b1;
      cycles(2);
      write_byte(8'h3C);
      dequeue(1);
      chk_data("midreset_byte", 8'h3C);
      chk_status("midreset_status", 1'b0);
      dequeue(1);
      chk_data("midreset_no_extra", 8'h3C);
   endtask

   initial begin
      bus.data_in    = 1'b0;
      bus.write_in   = 1'b0;
      bus.dequeue_in = 1'b0;
      test_reset();
      test_single_byte();
      test_fill();
      test_strobe_width();
      test_back_to_back();
      test_reset_mid_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
